// File: rtl/usb_rx_pkt_buffer.sv
// usb_rx_pkt_buffer: packs received bytes into words, stores whole packets in a circular RAM and lets the CPU drain them over Avalon-MM
module usb_rx_pkt_buffer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH_LOG2 = 10,
    parameter int PKTS_LOG2 = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic [7:0] in_data,
    input  logic in_valid,
    input  logic in_eop,
    output logic in_ready,
    input  logic [1:0] avs_address,
    input  logic avs_read,
    input  logic avs_write,
    input  logic [8*BYTES_PER_WORD-1:0] avs_writedata,
    output logic [8*BYTES_PER_WORD-1:0] avs_readdata,
    output logic avs_readdatavalid,
    output logic irq
);
    localparam int W = 8 * BYTES_PER_WORD;
    localparam int LW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    localparam int D = DEPTH_LOG2;
    localparam int NQ = 1 << PKTS_LOG2;
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DROP = 2'd2;

    logic [W-1:0] mem [1<<D];
    logic [W-1:0] ram_q, acc, word;
    logic [15:0] q_len [NQ];
    logic [15:0] q_words [NQ];
    logic [1:0] state;
    logic [D:0] wr_spec, wr_commit, rd_ptr, rd_nxt;
    logic [PKTS_LOG2-1:0] q_rd, q_wr;
    logic [PKTS_LOG2:0] q_count;
    logic [LW-1:0] lane, cur_lane;
    logic [15:0] len, wcnt, cur_len, cur_wcnt, head_len, head_words;
    logic [7:0] drop_cnt;
    logic [31:0] status, pkt_len;
    logic overflow, rdy, in_pkt, take, do_write, full, fail, we, push, pop, drop_evt;
    logic nonempty, ctrl_wr, discard, clr, flush, data_rd;
    logic unused_wdata;

    assign unused_wdata = ^avs_writedata[W-1:3];

    // byte packing, write/drop decisions, descriptor push/pop and next read pointer
    always_comb begin
        take = in_valid & in_ready;
        in_pkt = state != DROP;
        cur_len = state == IDLE ? 16'd0 : len;
        cur_wcnt = state == IDLE ? 16'd0 : wcnt;
        cur_lane = state == IDLE ? '0 : lane;
        word = (state == IDLE ? '0 : acc) | (W'(in_data) << {cur_lane, 3'b000});
        do_write = int'(cur_lane) == BYTES_PER_WORD - 1 || in_eop;
        full = (wr_spec - rd_ptr) == {1'b1, {D{1'b0}}};
        fail = (do_write & full) | (cur_len == 16'hFFFF);
        we = take & in_pkt & do_write & ~fail;
        nonempty = q_count != '0;
        ctrl_wr = avs_write & (avs_address == 2'd3);
        discard = ctrl_wr & avs_writedata[0];
        clr = ctrl_wr & avs_writedata[1];
        flush = ctrl_wr & avs_writedata[2];
        push = we & in_eop & ~flush;
        drop_evt = take & in_eop & ((state == DROP) | (in_pkt & fail));
        data_rd = avs_read & (avs_address == 2'd2) & nonempty;
        head_len = q_len[q_rd];
        head_words = q_words[q_rd];
        pop = nonempty & ~flush & (discard | (data_rd & (head_words == 16'd1)));
        rd_nxt = flush ? '0 : (discard & nonempty) ? rd_ptr + (D+1)'(head_words) : data_rd ? rd_ptr + 1'b1 : rd_ptr;
        in_ready = rdy & (q_count != (PKTS_LOG2+1)'(NQ));
        status = {8'd0, drop_cnt, 7'd0, overflow, 8'(q_count)};
        pkt_len = nonempty ? {head_words, head_len} : 32'd0;
    end

    // packet RAM; the read register follows the next rd_ptr and forwards a same-cycle write to that word
    always_ff @(posedge clk) begin
        if (we) mem[wr_spec[D-1:0]] <= word;
        ram_q <= (we && wr_spec[D-1:0] == rd_nxt[D-1:0]) ? word : mem[rd_nxt[D-1:0]];
    end

    // descriptor storage: push records length and word count, DATA reads count the head down
    always_ff @(posedge clk) begin
        if (push) begin
            q_len[q_wr] <= cur_len + 16'd1;
            q_words[q_wr] <= cur_wcnt + 16'd1;
        end
        if (data_rd & ~discard & ~flush) q_words[q_rd] <= head_words - 16'd1;
    end

    // write FSM, pointers, queue counters, sticky drop status and register read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wr_spec <= '0;
            wr_commit <= '0;
            rd_ptr <= '0;
            q_rd <= '0;
            q_wr <= '0;
            q_count <= '0;
            lane <= '0;
            len <= '0;
            wcnt <= '0;
            acc <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            rdy <= 1'b0;
            irq <= 1'b0;
            avs_readdata <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            rdy <= 1'b1;
            irq <= nonempty;
            rd_ptr <= rd_nxt;
            q_count <= flush ? '0 : q_count + (PKTS_LOG2+1)'(push) - (PKTS_LOG2+1)'(pop);
            q_wr <= flush ? '0 : q_wr + PKTS_LOG2'(push);
            q_rd <= flush ? '0 : q_rd + PKTS_LOG2'(pop);
            avs_readdatavalid <= avs_read;
            avs_readdata <= ~avs_read ? '0 : avs_address == 2'd0 ? W'(status) : avs_address == 2'd1 ? W'(pkt_len) : avs_address == 2'd2 ? (nonempty ? ram_q : '0) : '0;
            if (clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
            if (drop_evt) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            if (flush) begin
                state <= state == FILL ? DROP : IDLE;
                wr_spec <= '0;
                wr_commit <= '0;
            end else if (take) begin
                if (state == DROP || fail) begin
                    state <= in_eop ? IDLE : DROP;
                    if (in_eop) wr_spec <= wr_commit;
                end else begin
                    state <= in_eop ? IDLE : FILL;
                    len <= cur_len + 16'd1;
                    acc <= do_write ? '0 : word;
                    lane <= do_write ? '0 : cur_lane + 1'b1;
                    wcnt <= cur_wcnt + 16'(do_write);
                    if (do_write) wr_spec <= wr_spec + 1'b1;
                    if (in_eop) wr_commit <= wr_spec + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_pkt_buffer.sv
// tb_usb_rx_pkt_buffer: directed and random packets checked against a packet-level queue model
module tb_usb_rx_pkt_buffer;
    localparam int BPW = 4, DL = 4, PL = 4, CAP = 1 << DL, NQ = 1 << PL;

    logic clk = 0, reset = 1;
    logic [7:0] in_data;
    logic in_valid, in_eop, in_ready;
    logic [1:0] avs_address;
    logic avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic avs_readdatavalid, irq;

    always #5 clk = ~clk;

    usb_rx_pkt_buffer #(.BYTES_PER_WORD(BPW), .DEPTH_LOG2(DL), .PKTS_LOG2(PL)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop),
        .in_ready(in_ready), .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .irq(irq)
    );

    int n_checks = 0, n_fail = 0;
    logic [31:0] m_words[$];
    int m_len[$], m_rem[$];
    int m_drops = 0;
    bit m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {8'd0, 8'(m_drops > 255 ? 255 : m_drops), 7'd0, m_ovf, 8'(m_len.size())};
    endfunction

    function automatic logic [31:0] exp_pktlen();
        return m_len.size() == 0 ? 32'd0 : {16'(m_rem[0]), 16'(m_len[0])};
    endfunction

    task automatic model_pkt(input logic [7:0] b[$]);
        int nw = (b.size() + BPW - 1) / BPW;
        if (m_words.size() + nw > CAP) begin
            m_drops++;
            m_ovf = 1;
            return;
        end
        for (int i = 0; i < nw; i++) begin
            logic [31:0] w = 0;
            for (int k = 0; k < BPW; k++)
                if (i * BPW + k < b.size()) w[8*k +: 8] = b[i*BPW+k];
            m_words.push_back(w);
        end
        m_len.push_back(b.size());
        m_rem.push_back(nw);
    endtask

    task automatic gen(input int n, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic put_byte(input logic [7:0] d, input bit eop);
        int n = 0;
        @(negedge clk);
        in_data = d;
        in_valid = 1;
        in_eop = eop;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b[$], input bit gaps);
        foreach (b[i]) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(negedge clk);
                in_valid = 0;
            end
            put_byte(b[i], i == b.size() - 1);
        end
        @(negedge clk);
        in_valid = 0;
        in_eop = 0;
    endtask

    task automatic send_pkt(input logic [7:0] b[$]);
        send(b, 1);
        model_pkt(b);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read = 1;
        @(negedge clk);
        avs_read = 0;
        d = avs_readdata;
        check("readdatavalid", {31'd0, avs_readdatavalid}, 1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1;
        @(negedge clk);
        avs_write = 0;
    endtask

    task automatic rd_data();
        logic [31:0] d, e = 0;
        if (m_len.size() > 0) begin
            e = m_words.pop_front();
            m_rem[0]--;
            if (m_rem[0] == 0) begin
                void'(m_len.pop_front());
                void'(m_rem.pop_front());
            end
        end
        rd(2, d);
        check("data", d, e);
    endtask

    task automatic chk_status();
        logic [31:0] d;
        rd(0, d);
        check("status", d, exp_status());
    endtask

    task automatic chk_len();
        logic [31:0] d;
        rd(1, d);
        check("pkt_len", d, exp_pktlen());
    endtask

    task automatic do_discard();
        if (m_len.size() > 0) begin
            repeat (m_rem[0]) void'(m_words.pop_front());
            void'(m_len.pop_front());
            void'(m_rem.pop_front());
        end
        wr(3, 1);
    endtask

    task automatic do_clear();
        m_drops = 0;
        m_ovf = 0;
        wr(3, 2);
    endtask

    task automatic do_flush();
        m_words = {};
        m_len = {};
        m_rem = {};
        wr(3, 4);
    endtask

    initial begin
        logic [7:0] b[$];
        int guard;
        in_data = 0;
        in_valid = 0;
        in_eop = 0;
        avs_address = 0;
        avs_read = 0;
        avs_write = 0;
        avs_writedata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_readdata", avs_readdata, 0);
        check("rst_rdvalid", {31'd0, avs_readdatavalid}, 0);
        check("rst_irq", {31'd0, irq}, 0);
        reset = 0;
        #1 check("ready_before_clk", {31'd0, in_ready}, 0);
        @(negedge clk);
        check("ready_after_clk", {31'd0, in_ready}, 1);
        chk_status();
        chk_len();

        send_pkt({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        chk_status();
        chk_len();
        check("pktlen_6", exp_pktlen(), 32'h0002_0006);
        check("irq_high", {31'd0, irq}, 1);
        @(negedge clk);
        avs_address = 2;
        avs_read = 1;
        @(negedge clk);
        check("b2b_0", avs_readdata, 32'h0403_0201);
        @(negedge clk);
        avs_read = 0;
        check("b2b_1", avs_readdata, 32'h0000_0605);
        m_words = {};
        m_len = {};
        m_rem = {};
        chk_status();
        check("irq_low", {31'd0, irq}, 0);

        send_pkt({8'hAA});
        send_pkt({8'h11, 8'h12, 8'h13, 8'h14});
        chk_len();
        rd_data();
        chk_len();
        rd_data();
        chk_len();

        gen(68, b);
        send_pkt(b);
        chk_status();
        send_pkt({8'h21, 8'h22, 8'h23, 8'h24});
        chk_len();
        rd_data();
        do_clear();
        check("rdv_idle", {31'd0, avs_readdatavalid}, 0);

        chk_status();
        rd_data();
        chk_status();

        send_pkt({8'h31, 8'h32, 8'h33, 8'h34, 8'h35});
        put_byte(8'h41, 0);
        put_byte(8'h42, 0);
        put_byte(8'h43, 0);
        @(negedge clk);
        in_valid = 0;
        do_flush();
        chk_status();
        put_byte(8'h44, 0);
        put_byte(8'h45, 1);
        @(negedge clk);
        in_valid = 0;
        in_eop = 0;
        m_drops++;
        m_ovf = 1;
        chk_status();
        send_pkt({8'h51, 8'h52, 8'h53, 8'h54});
        chk_len();
        rd_data();

        do_flush();
        do_clear();
        for (int i = 0; i < NQ; i++) begin
            b = {8'(i + 8'h60)};
            send(b, 0);
            model_pkt(b);
        end
        check("qfull_ready", {31'd0, in_ready}, 0);
        chk_status();
        do_discard();
        check("qfull_ready_back", {31'd0, in_ready}, 1);
        chk_status();
        chk_len();
        rd_data();

        for (int it = 0; it < 300; it++) begin
            int op = $urandom_range(9);
            if (op < 4 && m_len.size() < NQ) begin
                gen($urandom_range(1, 40), b);
                send_pkt(b);
            end else if (op < 7) rd_data();
            else if (op == 7) chk_status();
            else if (op == 8) chk_len();
            else if ($urandom_range(1) == 1) do_discard();
            else do_clear();
        end
        guard = 0;
        while (m_len.size() > 0 && guard < 400) begin
            rd_data();
            guard++;
        end
        chk_status();
        chk_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
